// File: rtl/ic_fill_ctrl_if.sv
// Miss/fill handshake between the i-cache, the fill controller and the memory bus.
// The slave modport is the fill controller; master is the surrounding cache/memory side.
interface ic_fill_ctrl_if #(
  parameter int ADDR_W = 15,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
);
  logic              ic_miss;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_flush;
  logic [LINE_W-1:0] ic_fill_data;
  logic              ic_miss_ack;
  logic              fill_busy;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rd_valid;
  logic [BEAT_W-1:0] mem_rd_data;

  modport slave (
    input  ic_miss, ic_addr, ic_flush, mem_gnt, mem_rd_valid, mem_rd_data,
    output ic_fill_data, ic_miss_ack, fill_busy, mem_req, mem_addr
  );

  modport master (
    output ic_miss, ic_addr, ic_flush, mem_gnt, mem_rd_valid, mem_rd_data,
    input  ic_fill_data, ic_miss_ack, fill_busy, mem_req, mem_addr
  );
endinterface

// File: rtl/ic_fill_ctrl.sv
// I-cache miss responder: one burst read per miss, beats assembled into a line
// buffer, line returned with a single-cycle ack followed by a settle cycle.
module ic_fill_ctrl #(
  parameter int ADDR_W = 15,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  ic_fill_ctrl_if.slave bus
);
  localparam int NBEATS = LINE_W / BEAT_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    DATA  = 3'd2,
    DRAIN = 3'd3,
    ACK   = 3'd4,
    HOLD  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              ic_miss_ack_q, ic_miss_ack_d;
  logic              fill_busy_q, fill_busy_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              last_beat;
  logic              unused_offset;

  assign last_beat     = bus.mem_rd_valid && (beat_cnt_q == LAST_BEAT);
  assign unused_offset = ^bus.ic_addr[OFF_W-1:0];

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    mem_addr_d = mem_addr_q;
    line_d     = line_q;

    unique case (state_q)
      IDLE: begin
        if (bus.ic_miss && !bus.ic_flush) begin
          mem_addr_d = {bus.ic_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          state_d    = REQ;
        end
      end
      REQ: begin
        // A grant seen together with a flush is already committed on the bus,
        // so the burst still has to be absorbed.
        if (bus.mem_gnt) begin
          beat_cnt_d = '0;
          state_d    = bus.ic_flush ? DRAIN : DATA;
        end else if (bus.ic_flush) begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (bus.mem_rd_valid) beat_cnt_d = beat_cnt_q + CNT_W'(1);
        if (bus.ic_flush) begin
          state_d = last_beat ? IDLE : DRAIN;
        end else if (bus.mem_rd_valid) begin
          for (int k = 0; k < NBEATS; k++) begin
            if (CNT_W'(k) == beat_cnt_q) line_d[k*BEAT_W +: BEAT_W] = bus.mem_rd_data;
          end
          if (last_beat) state_d = ACK;
        end
      end
      DRAIN: begin
        if (bus.mem_rd_valid) beat_cnt_d = beat_cnt_q + CNT_W'(1);
        if (last_beat) state_d = IDLE;
      end
      ACK:     state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered images of the next state.
    mem_req_d     = (state_d == REQ);
    ic_miss_ack_d = (state_d == ACK);
    fill_busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      beat_cnt_q    <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      ic_miss_ack_q <= 1'b0;
      fill_busy_q   <= 1'b0;
      line_q        <= '0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      ic_miss_ack_q <= ic_miss_ack_d;
      fill_busy_q   <= fill_busy_d;
      line_q        <= line_d;
    end
  end

  assign bus.mem_req      = mem_req_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.ic_miss_ack  = ic_miss_ack_q;
  assign bus.fill_busy    = fill_busy_q;
  assign bus.ic_fill_data = line_q;
endmodule

// File: tb/tb_ic_fill_ctrl.sv
// Directed and randomized fills of ic_fill_ctrl, checked cycle by cycle against
// expectations derived from the transaction parameters.
module tb_ic_fill_ctrl;
  localparam int ADDR_W = 15;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int NB     = LINE_W / BEAT_W;

  // transaction kinds
  localparam int M_NORMAL    = 0;
  localparam int M_FLUSH_REQ = 1;
  localparam int M_FLUSH_DAT = 2;
  localparam int M_RESET     = 3;
  localparam int M_FLUSH_GNT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  ic_fill_ctrl_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W)) bus ();

  ic_fill_ctrl #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    bus.ic_miss      = 1'b0;
    bus.ic_addr      = '0;
    bus.ic_flush     = 1'b0;
    bus.mem_gnt      = 1'b0;
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},  LINE_W'(bus.mem_req), '0);
    chk({tag, "_addr"}, LINE_W'(bus.mem_addr), '0);
    chk({tag, "_ack"},  LINE_W'(bus.ic_miss_ack), '0);
    chk({tag, "_busy"}, LINE_W'(bus.fill_busy), '0);
    chk({tag, "_data"}, bus.ic_fill_data, '0);
  endtask

  // One miss transaction. gw: grant wait cycles, gap: idle cycles before each
  // beat, fb: beat index after which a flush/reset happens, fsame: a beat
  // arrives in the flush cycle, hold: leave ic_miss high after the ack,
  // fixed: beats k = {16{k}}, junk: stray read-valid outside the burst.
  task automatic fill(input logic [ADDR_W-1:0] addr, input int gw, input int gap,
                      input int mode, input int fb, input bit fsame, input bit hold,
                      input bit fixed, input bit junk);
    logic [BEAT_W-1:0] beats [NB];
    logic [LINE_W-1:0] exp_line;
    logic [ADDR_W-1:0] exp_addr;
    int lat;
    int exp_lat;
    int sent;

    exp_addr = ADDR_W'((int'(addr) / 32) * 32);
    for (int k = 0; k < NB; k++) begin
      if (fixed) beats[k] = {16{4'(k)}};
      else       beats[k] = {$urandom, $urandom};
    end
    exp_line = {beats[3], beats[2], beats[1], beats[0]};
    exp_lat  = (gw + 1) + NB * (gap + 1) + 1;
    sent     = 0;

    chk("idle_before", LINE_W'(bus.fill_busy), '0);
    bus.ic_miss = 1'b1;
    bus.ic_addr = addr;
    step();
    lat = 1;
    chk("req_raise", LINE_W'(bus.mem_req), 1);
    chk("req_addr",  LINE_W'(bus.mem_addr), LINE_W'(exp_addr));
    chk("busy_req",  LINE_W'(bus.fill_busy), 1);
    bus.ic_addr = ADDR_W'($urandom);

    for (int c = 0; c < gw; c++) begin
      bus.mem_rd_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.mem_rd_data  = {$urandom, $urandom};
      step();
      lat++;
      chk("req_hold",      LINE_W'(bus.mem_req), 1);
      chk("req_addr_hold", LINE_W'(bus.mem_addr), LINE_W'(exp_addr));
      chk("ack_in_req",    LINE_W'(bus.ic_miss_ack), '0);
    end
    bus.mem_rd_valid = 1'b0;

    if (mode == M_FLUSH_REQ) begin
      bus.ic_flush = 1'b1;
      bus.ic_miss  = 1'b0;
      step();
      bus.ic_flush = 1'b0;
      chk("flush_req_drop", LINE_W'(bus.mem_req), '0);
      chk("flush_req_idle", LINE_W'(bus.fill_busy), '0);
      for (int c = 0; c < 3; c++) begin
        step();
        chk("flush_req_quiet", LINE_W'(bus.mem_req), '0);
        chk("flush_req_noack", LINE_W'(bus.ic_miss_ack), '0);
      end
      return;
    end

    bus.mem_gnt = 1'b1;
    if (mode == M_FLUSH_GNT) begin
      bus.ic_flush = 1'b1;
      bus.ic_miss  = 1'b0;
    end
    step();
    lat++;
    bus.mem_gnt  = 1'b0;
    bus.ic_flush = 1'b0;
    chk("req_drop", LINE_W'(bus.mem_req), '0);
    chk("busy_gnt", LINE_W'(bus.fill_busy), 1);

    if (mode != M_FLUSH_GNT) begin
      for (int k = 0; k < NB; k++) begin
        for (int g = 0; g < gap; g++) begin
          step();
          lat++;
          chk("ack_gap", LINE_W'(bus.ic_miss_ack), '0);
        end
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = beats[k];
        step();
        lat++;
        bus.mem_rd_valid = 1'b0;
        sent++;
        if (k < NB - 1) begin
          chk("ack_early", LINE_W'(bus.ic_miss_ack), '0);
          chk("busy_data", LINE_W'(bus.fill_busy), 1);
        end
        if ((mode == M_FLUSH_DAT || mode == M_RESET) && k == fb) break;
      end
    end

    if (mode == M_RESET) begin
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst_async");
      step();
      step();
      chk_all_zero("rst_held");
      quiet_inputs();
      rst_n = 1'b1;
      step();
      chk("rst_release_idle", LINE_W'(bus.fill_busy), '0);
      return;
    end

    if (mode == M_FLUSH_DAT) begin
      bus.ic_flush     = 1'b1;
      bus.ic_miss      = 1'b0;
      bus.mem_rd_valid = fsame;
      bus.mem_rd_data  = {$urandom, $urandom};
      step();
      bus.ic_flush     = 1'b0;
      bus.mem_rd_valid = 1'b0;
      if (fsame) sent++;
      chk("flush_dat_noack", LINE_W'(bus.ic_miss_ack), '0);
      chk("flush_dat_busy",  LINE_W'(bus.fill_busy), 1);
    end

    if (mode == M_FLUSH_DAT || mode == M_FLUSH_GNT) begin
      for (int k = sent; k < NB; k++) begin
        for (int g = 0; g < gap; g++) begin
          bus.ic_flush = 1'($urandom_range(0, 1));
          step();
          chk("drain_noack_gap", LINE_W'(bus.ic_miss_ack), '0);
          chk("drain_busy_gap",  LINE_W'(bus.fill_busy), 1);
        end
        bus.ic_flush     = 1'($urandom_range(0, 1));
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = {$urandom, $urandom};
        step();
        bus.mem_rd_valid = 1'b0;
        bus.ic_flush     = 1'b0;
        chk("drain_noack", LINE_W'(bus.ic_miss_ack), '0);
        chk("drain_busy",  LINE_W'(bus.fill_busy), (k < NB - 1) ? 1 : 0);
      end
      step();
      chk("drain_after_noack", LINE_W'(bus.ic_miss_ack), '0);
      chk("drain_after_req",   LINE_W'(bus.mem_req), '0);
      return;
    end

    chk("ack_pulse",  LINE_W'(bus.ic_miss_ack), 1);
    chk("fill_line",  bus.ic_fill_data, exp_line);
    chk("miss_to_ack", LINE_W'(lat), LINE_W'(exp_lat));
    bus.ic_miss      = hold;
    bus.ic_flush     = 1'($urandom_range(0, 1));
    bus.mem_rd_valid = junk;
    step();
    bus.ic_flush     = 1'b0;
    chk("hold_noack", LINE_W'(bus.ic_miss_ack), '0);
    chk("hold_busy",  LINE_W'(bus.fill_busy), 1);
    chk("hold_noreq", LINE_W'(bus.mem_req), '0);
    step();
    bus.mem_rd_valid = 1'b0;
    chk("idle_noack", LINE_W'(bus.ic_miss_ack), '0);
    chk("idle_busy",  LINE_W'(bus.fill_busy), '0);
    chk("idle_noreq", LINE_W'(bus.mem_req), '0);
  endtask

  initial begin
    quiet_inputs();
    rst_n = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();
    chk_all_zero("post_reset");

    // basic fill, immediate grant, back-to-back beats
    fill(15'h1A7F, 0, 0, M_NORMAL, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    // delayed grant with stray valids, gapped beats
    fill(15'h2B13, 5, 2, M_NORMAL, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    // flush before grant
    fill(15'h0FFF, 2, 0, M_FLUSH_REQ, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    // flush after beat 1, then a fresh miss
    fill(15'h7123, 1, 0, M_FLUSH_DAT, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    fill(15'h0040, 0, 0, M_NORMAL, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    // flush coincident with grant
    fill(15'h5555, 3, 1, M_FLUSH_GNT, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    // async reset after beat 2, then a clean fill
    fill(15'h3333, 0, 0, M_RESET, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    fill(15'h4AA0, 0, 0, M_NORMAL, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    // miss held through HOLD starts exactly one new fill
    fill(15'h6E21, 0, 0, M_NORMAL, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    fill(15'h6E21, 0, 0, M_NORMAL, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      int m;
      int fbr;
      case ($urandom_range(0, 5))
        0, 1:    m = M_NORMAL;
        2:       m = M_FLUSH_REQ;
        3:       m = M_FLUSH_DAT;
        4:       m = M_RESET;
        default: m = M_FLUSH_GNT;
      endcase
      fbr = $urandom_range(0, 2);
      fill(ADDR_W'($urandom), $urandom_range(0, 4), $urandom_range(0, 2), m, fbr,
           (fbr <= 1) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
